// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the E-stage HI/LO divider.
//   - DIV_WIDTH   : default operand/result width
//   - DIV_CNT_W   : iteration-counter width for the default operand width
//   - div_state_t : divider sequencing states
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/hilo_div_unit_if.sv
// ---------------------------------------------------------------------------
// hilo_div_unit_if
//   Request/result bundle between the E stage and the HI/LO divider.
//   master (E stage) drives : start, sign, cancel, dividend, divisor
//   slave  (divider) drives : stall, done, quotient, remainder, div_zero
// ---------------------------------------------------------------------------
interface hilo_div_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             sign;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, sign, cancel, dividend, divisor,
    input  stall, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, sign, cancel, dividend, divisor,
    output stall, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/hilo_div_unit_lzc.sv
// ---------------------------------------------------------------------------
// div_lzc
//   Leading-zero counter used to skip the all-zero top of the dividend.
//   operand : value to scan (WIDTH bits)
//   count   : number of leading zeros; WIDTH when operand is zero
// ---------------------------------------------------------------------------
module div_lzc #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] operand,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit win the last assignment.
  // NOTE: always_comb assigns every output before any condition, so no latch is inferred.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (operand[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// ---------------------------------------------------------------------------
// hilo_div_unit
//   Iterative radix-2 restoring divider for the E stage. Produces one
//   quotient bit per cycle; HI takes the remainder, LO the quotient.
//   The pipeline is held via stall while the divide iterates.
//
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : hilo_div_unit_if.slave
//            start/sign/cancel/dividend/divisor in,
//            stall/done/quotient/remainder/div_zero out
//
//   Build option DIV_EARLY_OUT_EN: skip the leading zeros of |dividend|
//   so the iteration count becomes WIDTH minus that count.
// ---------------------------------------------------------------------------
module hilo_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  hilo_div_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t state, nextState;

  // Operation context captured on an accepted start.
  logic [WIDTH-1:0] quoShift;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] partRem;       // partial remainder; always below the divisor
  logic [WIDTH-1:0] absDivisor;
  logic [WIDTH-1:0] origDividend;  // returned untouched on divide-by-zero
  logic [CNT_W-1:0] iterCnt;
  logic             negQuo;
  logic             negRem;
  logic             zeroDiv;

  // Registered outputs.
  logic [WIDTH-1:0] quotientR;
  logic [WIDTH-1:0] remainderR;
  logic             doneR;
  logic             divZeroR;

  // ---------------------------------------------------------------------
  // Operand preparation at start
  // ---------------------------------------------------------------------
  logic             accept;
  logic [WIDTH-1:0] absDividendIn;
  logic [WIDTH-1:0] absDivisorIn;
  logic [WIDTH-1:0] loadShift;
  logic [CNT_W-1:0] loadCnt;
  logic             loadNegQuo;
  logic             loadNegRem;
  logic             loadZero;

  // cancel beats start; a request seen outside IDLE is never accepted.
  assign accept = (state == IDLE) && bus.start && !bus.cancel;

  // |MIN| negates back to MIN, whose unsigned reading is 2^(WIDTH-1).
  assign absDividendIn = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign absDivisorIn  = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  assign loadNegQuo    = bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
  assign loadNegRem    = bus.sign && bus.dividend[WIDTH-1];
  assign loadZero      = (bus.divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] leadZeros;

  div_lzc #(.WIDTH(WIDTH)) uLzc (
    .operand (absDividendIn),
    .count   (leadZeros)
  );

  // Leading zeros would only produce leading zero quotient bits; drop them.
  assign loadCnt   = CNT_W'(WIDTH) - leadZeros;
  assign loadShift = absDividendIn << leadZeros;
`else
  assign loadCnt   = CNT_W'(WIDTH);
  assign loadShift = absDividendIn;
`endif

  // ---------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------
  // The shifted partial remainder needs WIDTH+1 bits. The difference's top
  // bit is the borrow: the shifted value is below 2*divisor, so a
  // non-negative difference always fits in WIDTH bits.
  logic [WIDTH:0]   stepShift;
  logic [WIDTH:0]   stepDiff;
  logic             stepGe;
  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuo;

  assign stepShift = {partRem, quoShift[WIDTH-1]};
  assign stepDiff  = stepShift - {1'b0, absDivisor};
  assign stepGe    = !stepDiff[WIDTH];
  assign stepRem   = stepGe ? stepDiff[WIDTH-1:0] : stepShift[WIDTH-1:0];
  assign stepQuo   = {quoShift[WIDTH-2:0], stepGe};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    bus.stall = accept || (state == BUSY);
    unique case (state)
      IDLE: if (accept) nextState = (loadCnt == '0) ? DONE : BUSY;
      BUSY: begin
        if (bus.cancel)                 nextState = IDLE;
        else if (iterCnt == CNT_W'(1))  nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------
  // NOTE: working registers are not reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      quoShift     <= loadShift;
      partRem      <= '0;
      absDivisor   <= absDivisorIn;
      origDividend <= bus.dividend;
      negQuo       <= loadNegQuo;
      negRem       <= loadNegRem;
      zeroDiv      <= loadZero;
      iterCnt      <= loadCnt;
    end else if (state == BUSY) begin
      quoShift <= stepQuo;
      partRem  <= stepRem;
      iterCnt  <= iterCnt - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Result fix-up, registered on entry to DONE
  // ---------------------------------------------------------------------
  // A zero-length divide finishes straight from IDLE, so its context comes
  // from the bus rather than the working registers; its raw result is 0/0.
  logic             finishing;
  logic [WIDTH-1:0] rawQuo;
  logic [WIDTH-1:0] rawRem;
  logic             finNegQuo;
  logic             finNegRem;
  logic             finZero;
  logic [WIDTH-1:0] finOrig;
  logic [WIDTH-1:0] finQuo;
  logic [WIDTH-1:0] finRem;

  assign finishing = (nextState == DONE);

  always_comb begin
    rawQuo    = stepQuo;
    rawRem    = stepRem;
    finNegQuo = negQuo;
    finNegRem = negRem;
    finZero   = zeroDiv;
    finOrig   = origDividend;
    if (state == IDLE) begin
      rawQuo    = '0;
      rawRem    = '0;
      finNegQuo = loadNegQuo;
      finNegRem = loadNegRem;
      finZero   = loadZero;
      finOrig   = bus.dividend;
    end
    finQuo = finZero ? '1      : (finNegQuo ? -rawQuo : rawQuo);
    finRem = finZero ? finOrig : (finNegRem ? -rawRem : rawRem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      doneR      <= 1'b0;
      divZeroR   <= 1'b0;
      quotientR  <= '0;
      remainderR <= '0;
    end else begin
      doneR <= finishing;
      if (finishing) begin
        quotientR  <= finQuo;
        remainderR <= finRem;
        divZeroR   <= finZero;
      end
    end
  end

  assign bus.done      = doneR;
  assign bus.quotient  = quotientR;
  assign bus.remainder = remainderR;
  assign bus.div_zero  = divZeroR;

endmodule

// File: tb/tb_hilo_div_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_unit
//   Self-checking bench for hilo_div_unit (WIDTH = 32). A reference model
//   built on plain integer division predicts stall/done/results every
//   cycle; directed operations pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_hilo_div_unit;

  localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY   = 1'b1;
  localparam int LAT_100 = 8;
  localparam int LAT_M7  = 4;
  localparam int LAT_MIN = 33;
  localparam int LAT_5   = 4;
  localparam int LAT_20  = 6;
`else
  localparam bit EARLY   = 1'b0;
  localparam int LAT_100 = 33;
  localparam int LAT_M7  = 33;
  localparam int LAT_MIN = 33;
  localparam int LAT_5   = 33;
  localparam int LAT_20  = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  hilo_div_unit_if #(.WIDTH(W)) bus ();

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input bit s,
                                 output logic [31:0] q, output logic [31:0] r, output bit dz);
    int sa;
    int sb;
    sa = a;
    sb = b;
    dz = (b == 0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Iterations: bit length of |a| with early-out, otherwise the full width.
  function automatic int iterCount(input logic [31:0] a, input bit s);
    longint m;
    int     n;
    m = (s && a[31]) ? -longint'($signed(a)) : longint'(a);
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    return EARLY ? n : W;
  endfunction

  int          doneAt = -1;
  logic [31:0] heldQ = 0;
  logic [31:0] heldR = 0;
  bit          heldDz = 0;
  logic [31:0] pendQ;
  logic [31:0] pendR;
  bit          pendDz;

  always @(negedge clk) begin : compare
    bit busy;
    bit inDone;
    bit expStall;
    if (rst) begin
      doneAt = -1;
      heldQ  = 0;
      heldR  = 0;
      heldDz = 0;
    end else begin
      busy   = (doneAt >= 0) && (cyc < doneAt);
      inDone = (doneAt >= 0) && (cyc == doneAt);
      if (inDone) begin
        heldQ  = pendQ;
        heldR  = pendR;
        heldDz = pendDz;
      end
      expStall = busy || ((doneAt < 0) && bus.start && !bus.cancel);
      check("cyc_done", bus.done, inDone);
      check("cyc_stall", bus.stall, expStall);
      check("cyc_quotient", bus.quotient, heldQ);
      check("cyc_remainder", bus.remainder, heldR);
      check("cyc_div_zero", bus.div_zero, heldDz);
      if (inDone) doneAt = -1;
      else if (busy && bus.cancel) doneAt = -1;
      else if ((doneAt < 0) && bus.start && !bus.cancel) begin
        refDiv(bus.dividend, bus.divisor, bus.sign, pendQ, pendR, pendDz);
        doneAt = cyc + iterCount(bus.dividend, bus.sign) + 1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  // Holds start until done (start stays high through the DONE cycle) or a
  // random cancel. Returns at posedge+1 of the DONE cycle, or one cycle
  // after the cancel.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input bit allowCancel, output int lat, output bit cancelled);
    int t0;
    bit fin;
    bus.start    = 1'b1;
    bus.sign     = s;
    bus.dividend = a;
    bus.divisor  = b;
    bus.cancel   = 1'b0;
    t0 = cyc;
    lat = -1;
    cancelled = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = cyc - t0;
        fin = 1'b1;
      end else if (allowCancel && $urandom_range(0, 99) < 3) begin
        bus.cancel = 1'b1;
        bus.start  = 1'b0;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        cancelled  = 1'b1;
        fin = 1'b1;
      end
    end
    check("op_timeout", fin, 1'b1);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int          lat;
    bit          canc;
    int          t0;
    logic [31:0] a;
    logic [31:0] b;

    bus.start    = 1'b0;
    bus.sign     = 1'b0;
    bus.cancel   = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_done", bus.done, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_quotient", bus.quotient, 32'h0);
    check("rst_remainder", bus.remainder, 32'h0);
    check("rst_div_zero", bus.div_zero, 1'b0);
    @(posedge clk); #1;

    // 1: unsigned 100/7
    runOp(32'd100, 32'd7, 1'b0, 1'b0, lat, canc);
    check("t1_latency", lat, LAT_100);
    check("t1_quotient", bus.quotient, 32'd14);
    check("t1_remainder", bus.remainder, 32'd2);
    check("t1_div_zero", bus.div_zero, 1'b0);
    check("t1_stall_in_done", bus.stall, 1'b0);
    idle(2);

    // 2: signed -7/2
    runOp(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat, canc);
    check("t2_latency", lat, LAT_M7);
    check("t2_quotient", bus.quotient, 32'hFFFF_FFFD);
    check("t2_remainder", bus.remainder, 32'hFFFF_FFFF);
    idle(1);

    // 3: MIN / -1, signed then unsigned
    runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, canc);
    check("t3s_latency", lat, LAT_MIN);
    check("t3s_quotient", bus.quotient, 32'h8000_0000);
    check("t3s_remainder", bus.remainder, 32'h0);
    idle(1);
    runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, canc);
    check("t3u_quotient", bus.quotient, 32'h0);
    check("t3u_remainder", bus.remainder, 32'h8000_0000);
    idle(1);

    // 4: unsigned 5/0
    runOp(32'd5, 32'd0, 1'b0, 1'b0, lat, canc);
    check("t4_latency", lat, LAT_5);
    check("t4_quotient", bus.quotient, 32'hFFFF_FFFF);
    check("t4_remainder", bus.remainder, 32'd5);
    check("t4_div_zero", bus.div_zero, 1'b1);
    idle(1);

    // 5: cancel at T+10, new divide at T+12
    bus.start    = 1'b1;
    bus.sign     = 1'b0;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'd7;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    bus.start  = 1'b0;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    check("t5_stall_after_cancel", bus.stall, 1'b0);
    check("t5_cancel_cycle", cyc - t0, 11);
    @(posedge clk); #1;
    runOp(32'd20, 32'd4, 1'b0, 1'b0, lat, canc);
    check("t5_done_cycle", cyc - t0, 12 + LAT_20);
    check("t5_quotient", bus.quotient, 32'd5);
    check("t5_remainder", bus.remainder, 32'd0);
    idle(1);

`ifdef DIV_EARLY_OUT_EN
    // 6: early-out latencies; start stays high through DONE
    runOp(32'd9, 32'd3, 1'b0, 1'b0, lat, canc);
    check("t6a_latency", lat, 5);
    check("t6a_quotient", bus.quotient, 32'd3);
    check("t6a_stall_in_done", bus.stall, 1'b0);
    idle(1);
    runOp(32'd0, 32'd5, 1'b0, 1'b0, lat, canc);
    check("t6b_latency", lat, 1);
    check("t6b_quotient", bus.quotient, 32'd0);
    check("t6b_remainder", bus.remainder, 32'd0);
    check("t6b_stall_in_done", bus.stall, 1'b0);
    idle(1);
`endif

    // Random operations: back-to-back, gaps and occasional cancels.
    for (int i = 0; i < 250; i++) begin
      a = pick();
      b = pick();
      runOp(a, b, 1'($urandom_range(0, 1)), 1'b1, lat, canc);
      if (canc || $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // Reset in the middle of a divide clears outputs and suppresses done.
    bus.start    = 1'b1;
    bus.sign     = 1'b0;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_quotient", bus.quotient, 32'h0);
    check("midrst_remainder", bus.remainder, 32'h0);
    check("midrst_stall", bus.stall, 1'b0);
    idle(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
